// File: rtl/usb_enc_pkg.sv
// Shared types and CRC constants for the USB packet encoder.
package usb_enc_pkg;

    typedef enum logic {
        CRC5  = 1'b0,
        CRC16 = 1'b1
    } crc_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PID  = 2'd1,
        BODY = 2'd2,
        CRC  = 2'd3
    } state_t;

    localparam int unsigned PID_W   = 8;
    localparam int unsigned CRC5_W  = 5;
    localparam int unsigned CRC16_W = 16;

    localparam logic [CRC5_W-1:0]  CRC5_POLY  = 5'h05;
    localparam logic [CRC5_W-1:0]  CRC5_INIT  = 5'h1F;
    localparam logic [CRC16_W-1:0] CRC16_POLY = 16'h8005;
    localparam logic [CRC16_W-1:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/usb_crc_lfsr.sv
// Serial-input CRC LFSR: MSB feedback, reloaded with INIT on load.
module usb_crc_lfsr #(
    parameter int unsigned            WIDTH = 5,
    parameter logic [WIDTH-1:0]       POLY  = '0,
    parameter logic [WIDTH-1:0]       INIT  = '1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] crc
);

    logic fb;

    assign fb = din ^ crc[WIDTH-1];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            crc <= INIT;
        end else if (load) begin
            crc <= INIT;
        end else if (en) begin
            crc <= {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/usb_crc_serializer.sv
// USB packet serializer: PID, CRC-covered field, then CRC5/CRC16, LSB-first with per-bit backpressure.
module usb_crc_serializer
    import usb_enc_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [7:0]        pid,
    input  logic [DATA_W-1:0] pkt_data,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              crc_mode,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              bit_last
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 16);

    state_t            state;
    crc_mode_t         mode_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  crc_top;
    logic [CNT_W-1:0]  len_cnt;
    logic [PID_W-1:0]  pid_sh;
    logic [DATA_W-1:0] data_sh;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_clamp;
    logic [CRC5_W-1:0] crc5;
    logic [15:0]       crc16;
    logic [15:0]       crc_sel;
    logic [3:0]        crc_idx;
    logic              accept;
    logic              consume;
    logic              body_en;

    assign accept    = (state == IDLE) && pkt_valid;
    assign consume   = bit_valid && bit_ready;
    assign body_en   = (state == BODY) && consume;
    assign len_clamp = (pkt_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : pkt_len;
    assign len_cnt   = CNT_W'(len_q);

    assign crc_top = (mode_q == CRC16) ? CNT_W'(CRC16_W - 1) : CNT_W'(CRC5_W - 1);
    assign crc_sel = (mode_q == CRC16) ? crc16 : 16'(crc5);
    assign crc_idx = 4'(crc_top - cnt);

    assign pkt_ready = (state == IDLE);
    assign bit_valid = (state != IDLE);
    assign bit_last  = (state == CRC) && (cnt == crc_top);

    // PID and field are shifted out of bit 0; the CRC is frozen and indexed MSB-first.
    always_comb begin
        bit_out = 1'b0;
        case (state)
            PID:     bit_out = pid_sh[0];
            BODY:    bit_out = data_sh[0];
            CRC:     bit_out = ~crc_sel[crc_idx];
            default: bit_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= IDLE;
            cnt     <= '0;
            pid_sh  <= '0;
            data_sh <= '0;
            len_q   <= '0;
            mode_q  <= CRC5;
        end else begin
            case (state)
                IDLE: begin
                    if (pkt_valid) begin
                        state   <= PID;
                        cnt     <= '0;
                        pid_sh  <= pid;
                        data_sh <= pkt_data;
                        len_q   <= len_clamp;
                        mode_q  <= crc_mode_t'(crc_mode);
                    end
                end
                PID: begin
                    if (bit_ready) begin
                        pid_sh <= pid_sh >> 1;
                        if (cnt == CNT_W'(PID_W - 1)) begin
                            cnt   <= '0;
                            state <= (len_q == '0) ? CRC : BODY;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                BODY: begin
                    if (bit_ready) begin
                        data_sh <= data_sh >> 1;
                        if (cnt == len_cnt - CNT_W'(1)) begin
                            cnt   <= '0;
                            state <= CRC;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                CRC: begin
                    if (bit_ready) begin
                        if (cnt == crc_top) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    usb_crc_lfsr #(
        .WIDTH (CRC5_W),
        .POLY  (CRC5_POLY),
        .INIT  (CRC5_INIT)
    ) u_crc5 (
        .clk   (clk),
        .rst_b (rst_b),
        .load  (accept),
        .en    (body_en),
        .din   (data_sh[0]),
        .crc   (crc5)
    );

    usb_crc_lfsr #(
        .WIDTH (CRC16_W),
        .POLY  (CRC16_POLY),
        .INIT  (CRC16_INIT)
    ) u_crc16 (
        .clk   (clk),
        .rst_b (rst_b),
        .load  (accept),
        .en    (body_en),
        .din   (data_sh[0]),
        .crc   (crc16)
    );

endmodule

// File: doc/usb_crc_serializer.md
# usb_crc_serializer

Parametrised USB packet serializer that accepts a parallel packet (PID plus CRC-covered field), computes CRC5 or CRC16 on the fly, and emits the packet bit-serially, LSB-first, toward the bit stuffer. It replaces the fixed token-only CRC5 encoder. It supports both token (CRC5) and data (CRC16) packets of variable length, with per-bit backpressure from the stuffer.

## Interface
- DATA_W, 64: maximum CRC-covered field width in bits.
- LEN_W, $clog2(DATA_W+1): width of the length input.
- clk  input  1  clock, rising edge.
- rst_b  input  1  reset; asynchronous, active-low.
- pkt_valid  input  1  packet offered.
- pkt_ready  output  1  block can accept a packet (high only in IDLE).
- pid  input  8  PID byte, sent first, not CRC-covered.
- pkt_data  input  DATA_W  CRC-covered field; bit 0 is sent first.
- pkt_len  input  LEN_W  number of valid bits in pkt_data, 0..DATA_W.
- crc_mode  input  1  0 = CRC5, 1 = CRC16.
- bit_out  output  1  serial bit.
- bit_valid  output  1  bit_out is meaningful.
- bit_ready  input  1  stuffer consumes bit_out this cycle.
- bit_last  output  1  current bit is the final CRC bit.

## Operation
- States: IDLE, PID, BODY, CRC.
- IDLE: pkt_ready=1. On pkt_valid, latch pid, pkt_data, the clamped length, and crc_mode, then go to PID. The LFSR is loaded to all ones.
- Transfer rule: a bit is consumed only on a cycle with bit_valid && bit_ready. The index advances only on a consumed bit. bit_out and bit_valid are held stable while bit_ready=0.
- PID: send pid[0]..pid[7] (8 bits). After bit 7 is consumed, go to BODY, or go to CRC if the length is 0.
- BODY: send pkt_data[0]..pkt_data[len-1]. Each consumed bit updates the LFSR. After the last bit is consumed, go to CRC.
- CRC: send the complement of the LFSR, highest-order bit first. This is 5 bits in CRC5 mode and 16 bits in CRC16 mode. The LFSR does not update during CRC.
  - bit_last=1 on the final CRC bit.
  - When that bit is consumed, go to IDLE.
- CRC5: polynomial x^5+x^2+1 (0x05), init 5'h1F.
- CRC16: polynomial x^16+x^15+x^2+1 (0x8005), init 16'hFFFF.
- LFSR update per bit: fb = in ^ reg[MSB]; reg = (reg<<1) ^ (fb ? POLY : 0).
- pkt_len > DATA_W is clamped to DATA_W at latch time.
- Only the latched crc_mode and length are used; input changes during a packet are ignored.
- Reset (any time, including mid-packet):
  - state IDLE, LFSR all ones, counters 0.
  - pkt_ready=1, bit_valid=0, bit_out=0, bit_last=0.
  - The packet in progress is discarded; there is no partial completion.

## Timing
- Accept to first bit: the packet is accepted on edge N; bit_valid=1 with pid[0] appears after edge N (registered outputs, 1 cycle latency).
- With bit_ready held high, one bit per cycle; total 8+len+(5|16) cycles.
- The final bit is consumed at edge M; pkt_ready=1 after edge M. A new packet can be accepted at edge M+1, so there is one idle cycle between packets.
- pkt_ready and bit_valid are never both high.
- Counter width is $clog2(DATA_W+16) bits; it never wraps, because it is cleared on each state transition.

## Structure
- Package usb_enc_pkg: crc_mode_t enum (CRC5, CRC16), state_t enum, and constants CRC5_POLY, CRC5_INIT, CRC16_POLY, CRC16_INIT, PID_W=8.
- Sub-module usb_crc_lfsr, parametrised by WIDTH, POLY, and INIT. Ports: clk, rst_b, load, en, din, crc.
- The top level instantiates one CRC5 and one CRC16 LFSR and muxes between them by the latched mode.

## Test plan
- Token packet, bit_ready held at 1:
  - Stimulus: pid=8'hE1, pkt_data=11'h000, pkt_len=11, crc_mode=CRC5.
  - Required: 24 bits. The first 8 are 1,0,0,0,0,1,1,1, then 11 zeros, then CRC bits 0,1,0,0,0 (field 5'h02), with bit_last on bit 24.
- Empty data packet:
  - Stimulus: pid=8'hC3, pkt_len=0, crc_mode=CRC16.
  - Required: 8 PID bits, then 16 zero CRC bits; BODY is skipped; bit_last on bit 24.
- Backpressure:
  - Stimulus: the token above with bit_ready toggling 1,0,0,1 in a repeating pattern.
  - Required: an identical bit sequence, with bit_out held stable during stalls.
- Reset mid-packet:
  - Stimulus: assert rst_b=0 during BODY, then release.
  - Required: outputs at reset values immediately. The next token packet produces a correct CRC (not polluted by the prior LFSR state).
- Random data packets:
  - Stimulus: pkt_len from 1..DATA_W with random data, plus pkt_len=DATA_W+5.
  - Required: the CRC matches a reference model; the oversize length is clamped to DATA_W.
- Back-to-back packets:
  - Stimulus: pkt_valid held high across two packets.
  - Required: exactly one idle cycle between them, and the second packet's inputs are latched only when pkt_ready=1.
